alu_control_pipe: RTL and testbench
===================================

// Module: alu_control_pipe
// PURPOSE
//  Registered, handshaked successor to the single-cycle ALU decoder for the multi-cycle/pipelined MIPS core.
//  Decodes ALUOp/Funct into a widened ALU control code and passes a destination tag alongside it.
//  Sequences multi-cycle MULT/DIV: holds off new instructions for a fixed latency while md_busy is high.
//  Sits between the main control unit (ID) and the ALU/MD unit (EX).
// PARAMETERS
//  CTRL_W   4   width of alu_ctrl; must be >= 4, upper bits zero-filled.
//  TAG_W    5   width of the passthrough tag (destination register number).
//  MUL_LAT  4   MULT busy cycles; must be >= 1.
//  DIV_LAT  32  DIV busy cycles; must be >= 1.
//  localparam CNT_W = $clog2(max(MUL_LAT,DIV_LAT)+1).
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  in_valid   in   1       ALUOp/Funct/tag valid
//  in_ready   out  1       block can accept this cycle
//  alu_op     in   2       00 add, 01 sub, 10 R-type (use funct), 11 slt (slti)
//  funct      in   6       Instruction[5:0]
//  tag_in     in   TAG_W   passthrough tag
//  out_valid  out  1       alu_ctrl/tag_out valid
//  out_ready  in   1       downstream accepts
//  alu_ctrl   out  CTRL_W  ALU operation code
//  tag_out    out  TAG_W   registered tag_in
//  md_start   out  1       1-cycle pulse: MULT/DIV issued
//  md_busy    out  1       MULT/DIV in progress
//  illegal    out  1       [ALU_DEC_ILLEGAL_TRAP_EN only] sticky unknown-funct flag
// BEHAVIOUR
//  Reset (sync, high): out_valid=0, alu_ctrl=0, tag_out=0, md_start=0, md_busy=0, illegal=0, state=IDLE.
//  Decode: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 1101, NOR 1100, SLT 0111, SLTU 1111, SLL 1000,
//   SRL 1001, SRA 1010, MULT 0011, DIV 0100. alu_op 00->ADD, 01->SUB, 11->SLT, 10->funct lookup:
//   100000/100001 ADD, 100010/100011 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT,
//   101011 SLTU, 000000 SLL, 000010 SRL, 000011 SRA, 011000/011001 MULT, 011010/011011 DIV.
//   Unknown funct -> ADD; decode is fully specified, no latched state.
//  Handshake: accept when in_valid && in_ready. in_ready = state==IDLE && (!out_valid || out_ready).
//   Latency 1: accepted op appears on alu_ctrl/tag_out with out_valid on the next cycle.
//   out_valid && !out_ready: alu_ctrl/tag_out held stable, in_ready=0.
//   out_valid && out_ready && in_valid: back-to-back, one op/cycle throughput.
//  FSM IDLE/MD_BUSY: accepting MULT or DIV -> MD_BUSY, counter loaded with MUL_LAT or DIV_LAT;
//   md_start=1 and md_busy=1 in cycle 1 after acceptance; counter decrements each cycle;
//   md_busy high for exactly LAT cycles (1..LAT); at count 1 -> IDLE; in_ready may rise in cycle LAT+1.
//   out_valid for the MD op is unaffected by busy (ALU gets its code at once).
//  Reset mid-MD_BUSY: counter cleared, IDLE next cycle, in-flight op discarded.
//  Non-R alu_op never enters MD_BUSY, whatever funct holds.
// CONFIGURATION
//  `ALU_DEC_ILLEGAL_TRAP_EN defined: illegal port present; set on accepting alu_op=10 with unknown funct;
//   stays 1 until reset; op still issued as ADD.
//  Undefined: no illegal port; unknown funct silently decodes ADD.
// STRUCTURE
//  alu_dec_pkg: ALU_* control encodings, FUNCT_* constants, ALUOP_* codes, state enum (IDLE, MD_BUSY).
//  Sub-module md_latency_counter (load value, load strobe, busy, done) instantiated once.
//  Decode is a combinational function in the package; pipeline register and FSM in this module.
// TESTING
//  1 Reset: assert reset 2 cycles with in_valid=1 -> all outputs 0, in_ready=1 after release.
//  2 Back-to-back: ops alu_op=10, funct 100000,100010,100100,100101,101010 with out_ready=1 -> alu_ctrl
//    0010,0110,0000,0001,0111 on consecutive cycles, tags match, in_ready stays 1.
//  3 Backpressure: out_ready=0 for 3 cycles after SUB -> alu_ctrl=0110 held, in_ready=0, no op lost.
//  4 MULT with MUL_LAT=4: funct 011000 -> alu_ctrl=0011, md_start one cycle, md_busy exactly 4 cycles,
//    next op accepted cycle 5; DIV_LAT=32 with 011010 -> 32 busy cycles.
//  5 Reset at busy cycle 2 of DIV -> md_busy=0, in_ready=1 the cycle after reset deasserts.
//  6 Unknown funct 111111, alu_op=10 -> alu_ctrl=0010; with macro, illegal=1 sticky until reset;
//    alu_op=00 with funct 011000 -> ADD, no md_busy.

Source files
------------

// File: rtl/alu_dec_pkg.sv
// alu_dec_pkg: ALU control encodings, funct/aluop codes, FSM states and the combinational decoder.
package alu_dec_pkg;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MULT = 4'b0011;
    localparam logic [3:0] ALU_DIV  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_XOR  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_SRA   = 6'b000011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    typedef enum logic {IDLE, MD_BUSY} state_t;

    // Unknown R-type funct falls through to ADD.
    function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] fn);
        logic [3:0] c;
        c = ALU_ADD;
        if (op == ALUOP_SUB) c = ALU_SUB;
        else if (op == ALUOP_SLT) c = ALU_SLT;
        else if (op == ALUOP_RTYPE) begin
            case (fn)
                FUNCT_SUB, FUNCT_SUBU:   c = ALU_SUB;
                FUNCT_AND:               c = ALU_AND;
                FUNCT_OR:                c = ALU_OR;
                FUNCT_XOR:               c = ALU_XOR;
                FUNCT_NOR:               c = ALU_NOR;
                FUNCT_SLT:               c = ALU_SLT;
                FUNCT_SLTU:              c = ALU_SLTU;
                FUNCT_SLL:               c = ALU_SLL;
                FUNCT_SRL:               c = ALU_SRL;
                FUNCT_SRA:               c = ALU_SRA;
                FUNCT_MULT, FUNCT_MULTU: c = ALU_MULT;
                FUNCT_DIV, FUNCT_DIVU:   c = ALU_DIV;
                default:                 c = ALU_ADD;
            endcase
        end
        return c;
    endfunction

    function automatic logic funct_known(input logic [5:0] fn);
        return fn inside {FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU, FUNCT_AND, FUNCT_OR,
                          FUNCT_XOR, FUNCT_NOR, FUNCT_SLT, FUNCT_SLTU, FUNCT_SLL, FUNCT_SRL,
                          FUNCT_SRA, FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    endfunction
endpackage

// File: rtl/md_latency_counter.sv
// md_latency_counter: down-counter timing a MULT/DIV; busy while nonzero, done on its last cycle.
module md_latency_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             done
);
    logic [CNT_W-1:0] count;
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (load) count <= load_val;
        else if (count != '0) count <= count - 1'b1;
    end
    assign busy = count != '0;
    assign done = count == CNT_W'(1);
endmodule

// File: rtl/alu_control_pipe.sv
// alu_control_pipe: registered handshaked ALU decoder with MULT/DIV busy sequencing.
// Optional sticky illegal-funct flag enabled by `ALU_DEC_ILLEGAL_TRAP_EN.
module alu_control_pipe
    import alu_dec_pkg::*;
#(
    parameter int CTRL_W  = 4,
    parameter int TAG_W   = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [TAG_W-1:0]  tag_out,
    output logic              md_start,
    output logic              md_busy
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
   ,output logic              illegal
`endif
);
    localparam int MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
    localparam int CNT_W = $clog2(MAX_LAT + 1);

    state_t           state;
    logic [3:0]       dec_ctrl;
    logic             dec_md, accept, md_done;
    logic [CNT_W-1:0] lat;

    assign dec_ctrl = alu_decode(alu_op, funct);
    // MULT/DIV codes only come out of the R-type lookup, so non-R ops never start the unit.
    assign dec_md   = dec_ctrl == ALU_MULT || dec_ctrl == ALU_DIV;
    assign in_ready = state == IDLE && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign lat      = dec_ctrl == ALU_MULT ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);

    md_latency_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept && dec_md),
        .load_val (lat),
        .busy     (md_busy),
        .done     (md_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            alu_ctrl  <= '0;
            tag_out   <= '0;
            md_start  <= 1'b0;
        end else begin
            md_start <= accept && dec_md;
            if (accept) begin
                out_valid <= 1'b1;
                alu_ctrl  <= CTRL_W'(dec_ctrl);
                tag_out   <= tag_in;
            end else if (out_ready) out_valid <= 1'b0;
            if (accept && dec_md) state <= MD_BUSY;
            else if (state == MD_BUSY && md_done) state <= IDLE;
        end
    end

`ifdef ALU_DEC_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) illegal <= 1'b0;
        else if (accept && alu_op == ALUOP_RTYPE && !funct_known(funct)) illegal <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_alu_control_pipe.sv
// tb_alu_control_pipe: directed and random stimulus against a timestamp-based reference model.
module tb_alu_control_pipe;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic       clk = 1'b0;
    logic       reset, in_valid, in_ready, out_valid, out_ready, md_start, md_busy;
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic [4:0] tag_in, tag_out;
    logic [3:0] alu_ctrl;
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int total = 0, bad = 0;
    int cyc = 0, md_first = -1, md_last = -1, busy_seen = 0;
    logic       m_ov = 1'b0, m_ill = 1'b0;
    logic [3:0] m_ctrl = 4'd0;
    logic [4:0] m_tag = 5'd0;
    logic [4:0] ftab [64];
    logic [5:0] legal [17];
    logic [5:0] b2b [5];

    always #5 clk = ~clk;

    alu_control_pipe #(.CTRL_W(4), .TAG_W(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctrl  (alu_ctrl),
        .tag_out   (tag_out),
        .md_start  (md_start),
        .md_busy   (md_busy)
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
       ,.illegal   (illegal)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ftab entry = {known, code}; unknown funct and non-R ops map by rule, not by table miss.
    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] fn);
        return op == 2'b00 ? 4'b0010 : op == 2'b01 ? 4'b0110 : op == 2'b11 ? 4'b0111 : ftab[fn][3:0];
    endfunction

    function automatic logic m_busy();
        return cyc >= md_first && cyc <= md_last;
    endfunction

    function automatic logic m_rdy(input logic ordy);
        return !m_busy() && (!m_ov || ordy);
    endfunction

    task automatic step(input logic iv, input logic [1:0] op, input logic [5:0] fn,
                        input logic [4:0] tg, input logic ordy, input logic rst);
        logic [3:0] c;
        in_valid = iv; alu_op = op; funct = fn; tag_in = tg; out_ready = ordy; reset = rst;
        #1;
        check("in_ready", 32'(in_ready), 32'(m_rdy(ordy)));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
        check("tag_out", 32'(tag_out), 32'(m_tag));
        check("md_start", 32'(md_start), 32'(cyc == md_first));
        check("md_busy", 32'(md_busy), 32'(m_busy()));
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
        check("illegal", 32'(illegal), 32'(m_ill));
`endif
        if (md_busy === 1'b1) busy_seen++;
        @(posedge clk);
        if (rst) begin
            m_ov = 1'b0; m_ctrl = 4'd0; m_tag = 5'd0; m_ill = 1'b0; md_first = -1; md_last = -1;
        end else if (iv && m_rdy(ordy)) begin
            c = ref_ctrl(op, fn);
            m_ov = 1'b1; m_ctrl = c; m_tag = tg;
            if (c == 4'b0011 || c == 4'b0100) begin
                md_first = cyc + 1;
                md_last  = cyc + (c == 4'b0011 ? MUL_LAT : DIV_LAT);
            end
            if (op == 2'b10 && !ftab[fn][4]) m_ill = 1'b1;
        end else if (ordy) m_ov = 1'b0;
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 6'd0, 5'd0, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ftab[i] = 5'b0_0010;
        ftab[6'b100000] = 5'b1_0010; ftab[6'b100001] = 5'b1_0010;
        ftab[6'b100010] = 5'b1_0110; ftab[6'b100011] = 5'b1_0110;
        ftab[6'b100100] = 5'b1_0000; ftab[6'b100101] = 5'b1_0001;
        ftab[6'b100110] = 5'b1_1101; ftab[6'b100111] = 5'b1_1100;
        ftab[6'b101010] = 5'b1_0111; ftab[6'b101011] = 5'b1_1111;
        ftab[6'b000000] = 5'b1_1000; ftab[6'b000010] = 5'b1_1001;
        ftab[6'b000011] = 5'b1_1010;
        ftab[6'b011000] = 5'b1_0011; ftab[6'b011001] = 5'b1_0011;
        ftab[6'b011010] = 5'b1_0100; ftab[6'b011011] = 5'b1_0100;
        legal = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                  6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                  6'b000011, 6'b011000, 6'b011001, 6'b011010, 6'b011011};
        b2b = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        reset = 1'b1; in_valid = 1'b1; alu_op = 2'b10; funct = 6'b100000; tag_in = 5'd3; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 2'b10, 6'b100000, 5'd3, 1'b1, 1'b1);
        step(1'b1, 2'b10, 6'b100000, 5'd3, 1'b1, 1'b1);
        idle(1);

        for (int i = 0; i < 5; i++) step(1'b1, 2'b10, b2b[i], 5'(i + 1), 1'b1, 1'b0);
        idle(2);

        step(1'b1, 2'b10, 6'b100010, 5'd7, 1'b1, 1'b0);
        repeat (3) step(1'b1, 2'b00, 6'd0, 5'd8, 1'b0, 1'b0);
        step(1'b1, 2'b00, 6'd0, 5'd8, 1'b1, 1'b0);
        idle(2);

        busy_seen = 0;
        step(1'b1, 2'b10, 6'b011000, 5'd9, 1'b1, 1'b0);
        repeat (6) step(1'b1, 2'b00, 6'd0, 5'd10, 1'b1, 1'b0);
        check("mult_busy_len", 32'(busy_seen), 32'(MUL_LAT));
        idle(2);

        busy_seen = 0;
        step(1'b1, 2'b10, 6'b011010, 5'd11, 1'b1, 1'b0);
        idle(DIV_LAT + 2);
        check("div_busy_len", 32'(busy_seen), 32'(DIV_LAT));

        step(1'b1, 2'b10, 6'b011011, 5'd12, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 2'b00, 6'd0, 5'd0, 1'b1, 1'b1);
        step(1'b1, 2'b01, 6'd0, 5'd13, 1'b1, 1'b0);
        idle(2);

        step(1'b1, 2'b10, 6'b111111, 5'd14, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 2'b00, 6'b011000, 5'd15, 1'b1, 1'b0);
        idle(3);
        step(1'b0, 2'b00, 6'd0, 5'd0, 1'b1, 1'b1);
        idle(1);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 4) == 0 ? 6'($urandom) : legal[$urandom_range(0, 16)],
                 5'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
